rggen_host_arbiter: RTL and testbench

Shares the register block's single internal command bus between `HOSTS` host-interface bridges (e.g. an APB port and a debug port). Each host presents a command/response channel identical to the bus the host bridges already drive into `rggen_response_mux` and the address decoders. The block sits between the host bridges and that bus. It grants one host at a time with round-robin fairness, holds the grant until the addressed register responds, and returns the response to the granted host only.

---
 rtl/rggen_host_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_rggen_host_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rggen_host_arbiter.sv
// -----------------------------------------------------------------------------
// rggen_host_arbiter
//
// Shares the register block's single internal command bus between HOSTS
// host-interface bridges. One host owns the bus at a time, picked
// round-robin. The owner keeps the bus until the addressed register returns
// its response strobe. That strobe is routed back to the owner only.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   i_command_valid     [HOSTS]            per-host command request
//   i_write, i_read     [HOSTS]            per-host access type (one-hot or zero)
//   i_address           [HOSTS][ADDR]      per-host byte address
//   i_write_data        [HOSTS][DATA]      per-host write data
//   i_write_mask        [HOSTS][DATA]      per-host write bit mask
//   o_response_ready    [HOSTS]            per-host response strobe
//   o_read_data         [DATA]             read data, shared by all hosts
//   o_status            [2]                response status, shared by all hosts
//   o_command_valid .. o_write_mask        downstream command bus
//   i_response_ready, i_read_data, i_status  downstream response
//   o_grant             [HOSTS]            one-hot current owner, zero when idle
// -----------------------------------------------------------------------------
module rggen_host_arbiter #(
    parameter int HOSTS         = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 7
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [HOSTS-1:0]                          i_command_valid,
    input  logic [HOSTS-1:0]                          i_write,
    input  logic [HOSTS-1:0]                          i_read,
    input  logic [HOSTS-1:0][ADDRESS_WIDTH-1:0]       i_address,
    input  logic [HOSTS-1:0][DATA_WIDTH-1:0]          i_write_data,
    input  logic [HOSTS-1:0][DATA_WIDTH-1:0]          i_write_mask,
    output logic [HOSTS-1:0]                          o_response_ready,
    output logic [DATA_WIDTH-1:0]                     o_read_data,
    output logic [1:0]                                o_status,
    output logic                                      o_command_valid,
    output logic                                      o_write,
    output logic                                      o_read,
    output logic [ADDRESS_WIDTH-1:0]                  o_address,
    output logic [DATA_WIDTH-1:0]                     o_write_data,
    output logic [DATA_WIDTH-1:0]                     o_write_mask,
    input  logic                                      i_response_ready,
    input  logic [DATA_WIDTH-1:0]                     i_read_data,
    input  logic [1:0]                                i_status,
    output logic [HOSTS-1:0]                          o_grant
);

    localparam int IDX_W = (HOSTS > 1) ? $clog2(HOSTS) : 1;
    // One extra bit so that pointer + offset never overflows before the wrap.
    localparam int CW    = IDX_W + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e             state_r;
    state_e             state_s;
    logic [IDX_W-1:0]   grant_idx_r;
    logic [IDX_W-1:0]   grant_idx_s;
    logic [IDX_W-1:0]   ptr_r;
    logic [IDX_W-1:0]   ptr_s;
    logic [HOSTS-1:0]   grant_r;
    logic [HOSTS-1:0]   grant_s;
    logic [IDX_W-1:0]   winner_s;
    logic [IDX_W-1:0]   next_ptr_s;
    logic [CW-1:0]      cand_s;
    logic               found_s;
    logic               busy_s;

    function automatic logic [HOSTS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [HOSTS-1:0] oh;
        oh      = {HOSTS{1'b0}};
        oh[idx] = 1'b1;
        return oh;
    endfunction

    assign busy_s = (state_r == ST_BUSY);

    // Round-robin search: first requesting host at or after the pointer, wrapping.
    always_comb begin
        winner_s = ptr_r;
        found_s  = 1'b0;
        cand_s   = {CW{1'b0}};
        for (int off = 0; off < HOSTS; off++) begin
            cand_s = {1'b0, ptr_r} + CW'(off);
            if (cand_s >= CW'(HOSTS)) begin
                cand_s = cand_s - CW'(HOSTS);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && i_command_valid[cand_s[IDX_W-1:0]]) begin
                winner_s = cand_s[IDX_W-1:0];
                found_s  = 1'b1;
            end else begin
                winner_s = winner_s;
            end
        end
    end

    // Pointer value after the current owner finishes: owner + 1, wrapping to 0.
    always_comb begin
        if (grant_idx_r == IDX_W'(HOSTS - 1)) begin
            next_ptr_s = {IDX_W{1'b0}};
        end else begin
            next_ptr_s = grant_idx_r + IDX_W'(1);
        end
    end

    // State register: FSM state, owner index, round-robin pointer, one-hot grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            grant_idx_r <= {IDX_W{1'b0}};
            ptr_r       <= {IDX_W{1'b0}};
            grant_r     <= {HOSTS{1'b0}};
        end else begin
            state_r     <= state_s;
            grant_idx_r <= grant_idx_s;
            ptr_r       <= ptr_s;
            grant_r     <= grant_s;
        end
    end

    // Next-state logic: grant on any request, release on the response strobe.
    always_comb begin
        state_s     = state_r;
        grant_idx_s = grant_idx_r;
        ptr_s       = ptr_r;
        grant_s     = grant_r;
        case (state_r)
            ST_IDLE: begin
                // A response strobe seen here is spurious and deliberately ignored.
                if (|i_command_valid) begin
                    state_s     = ST_BUSY;
                    grant_idx_s = winner_s;
                    grant_s     = idx_to_onehot(winner_s);
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (i_response_ready) begin
                    state_s = ST_IDLE;
                    ptr_s   = next_ptr_s;
                    grant_s = {HOSTS{1'b0}};
                end else begin
                    state_s = ST_BUSY;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                grant_idx_s = {IDX_W{1'b0}};
                ptr_s       = {IDX_W{1'b0}};
                grant_s     = {HOSTS{1'b0}};
            end
        endcase
    end

    // Output logic: owner's command muxed downstream, response routed to owner.
    // Response data/status are also forced to zero when idle so that every
    // output reads zero while the block is held in reset.
    always_comb begin
        o_write          = 1'b0;
        o_read           = 1'b0;
        o_address        = {ADDRESS_WIDTH{1'b0}};
        o_write_data     = {DATA_WIDTH{1'b0}};
        o_write_mask     = {DATA_WIDTH{1'b0}};
        o_response_ready = {HOSTS{1'b0}};
        o_read_data      = {DATA_WIDTH{1'b0}};
        o_status         = 2'b00;
        if (busy_s) begin
            o_write          = i_write[grant_idx_r];
            o_read           = i_read[grant_idx_r];
            o_address        = i_address[grant_idx_r];
            o_write_data     = i_write_data[grant_idx_r];
            o_write_mask     = i_write_mask[grant_idx_r];
            o_response_ready = i_response_ready ? grant_r : {HOSTS{1'b0}};
            o_read_data      = i_read_data;
            o_status         = i_status;
        end else begin
            o_response_ready = {HOSTS{1'b0}};
        end
    end

    assign o_command_valid = busy_s;
    assign o_grant         = grant_r;

endmodule

// File: tb/tb_rggen_host_arbiter.sv
// Self-checking bench: directed scenarios on a 2-host and a 3-host instance,
// then randomized traffic on the 3-host instance against a behavioural model.
`define CHK(tag, obs, exp) chk(tag, 64'(obs), 64'(exp))

module tb_rggen_host_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // ---------------- 2-host instance ----------------
    logic [1:0]        a_cv, a_wr, a_rd, a_rr, a_grant;
    logic [1:0][6:0]   a_addr;
    logic [1:0][31:0]  a_wd, a_wm;
    logic [31:0]       a_rdata, a_owd, a_owm, a_ird;
    logic [1:0]        a_st, a_ist;
    logic              a_ocv, a_ow, a_or, a_irr;
    logic [6:0]        a_oaddr;

    rggen_host_arbiter #(.HOSTS(2), .DATA_WIDTH(32), .ADDRESS_WIDTH(7)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .i_command_valid(a_cv), .i_write(a_wr), .i_read(a_rd), .i_address(a_addr),
        .i_write_data(a_wd), .i_write_mask(a_wm),
        .o_response_ready(a_rr), .o_read_data(a_rdata), .o_status(a_st),
        .o_command_valid(a_ocv), .o_write(a_ow), .o_read(a_or), .o_address(a_oaddr),
        .o_write_data(a_owd), .o_write_mask(a_owm),
        .i_response_ready(a_irr), .i_read_data(a_ird), .i_status(a_ist),
        .o_grant(a_grant)
    );

    // ---------------- 3-host instance ----------------
    logic [2:0]        b_cv, b_wr, b_rd, b_rr, b_grant;
    logic [2:0][6:0]   b_addr;
    logic [2:0][31:0]  b_wd, b_wm;
    logic [31:0]       b_rdata, b_owd, b_owm, b_ird;
    logic [1:0]        b_st, b_ist;
    logic              b_ocv, b_ow, b_or, b_irr;
    logic [6:0]        b_oaddr;

    rggen_host_arbiter #(.HOSTS(3), .DATA_WIDTH(32), .ADDRESS_WIDTH(7)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .i_command_valid(b_cv), .i_write(b_wr), .i_read(b_rd), .i_address(b_addr),
        .i_write_data(b_wd), .i_write_mask(b_wm),
        .o_response_ready(b_rr), .o_read_data(b_rdata), .o_status(b_st),
        .o_command_valid(b_ocv), .o_write(b_ow), .o_read(b_or), .o_address(b_oaddr),
        .o_write_data(b_owd), .o_write_mask(b_owm),
        .i_response_ready(b_irr), .i_read_data(b_ird), .i_status(b_ist),
        .o_grant(b_grant)
    );

    // ---------------- reference model state (3-host) ----------------
    bit          m_busy;
    int          m_g, m_p;
    bit          pend [3];
    logic        m_wr [3];
    logic        m_rd [3];
    logic [6:0]  m_addr [3];
    logic [31:0] m_wd [3];
    logic [31:0] m_wm [3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic chk_a_zero(input string tag);
        `CHK({tag, "_cv"},    a_ocv,   0);
        `CHK({tag, "_wr"},    a_ow,    0);
        `CHK({tag, "_rd"},    a_or,    0);
        `CHK({tag, "_addr"},  a_oaddr, 0);
        `CHK({tag, "_wdata"}, a_owd,   0);
        `CHK({tag, "_wmask"}, a_owm,   0);
        `CHK({tag, "_grant"}, a_grant, 0);
        `CHK({tag, "_rr"},    a_rr,    0);
        `CHK({tag, "_rdata"}, a_rdata, 0);
        `CHK({tag, "_st"},    a_st,    0);
    endtask

    // Round-robin pick from the spec rule: first pending host in order p, p+1, ...
    function automatic int pick(input int p);
        int idx;
        for (int k = 0; k < 3; k++) begin
            idx = (p + k) % 3;
            if (pend[idx]) return idx;
        end
        return -1;
    endfunction

    initial begin
        logic [1:0] fexp;
        int         kind;
        logic [2:0] exp_grant;
        logic [2:0] exp_rr;

        rst_n = 1'b0;
        a_cv = '0; a_wr = '0; a_rd = '0; a_addr = '0; a_wd = '0; a_wm = '0;
        a_irr = 1'b0; a_ird = '0; a_ist = '0;
        b_cv = '0; b_wr = '0; b_rd = '0; b_addr = '0; b_wd = '0; b_wm = '0;
        b_irr = 1'b0; b_ird = '0; b_ist = '0;
        #2;
        chk_a_zero("reset");
        `CHK("reset_b_cv", b_ocv, 0);
        `CHK("reset_b_grant", b_grant, 0);
        tick();
        rst_n = 1'b1;
        settle();

        // ---- Fairness: both hosts request continuously, 1-cycle responses ----
        tick();
        a_cv = 2'b11; a_rd = 2'b11; a_addr[0] = 7'h08; a_addr[1] = 7'h10;
        settle();
        `CHK("fair_idle0", a_ocv, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            a_irr = 1'b1; a_ird = 32'(i);
            settle();
            fexp = (i % 2 == 0) ? 2'b01 : 2'b10;
            `CHK("fair_grant", a_grant, fexp);
            `CHK("fair_strobe", a_rr, fexp);
            `CHK("fair_addr", a_oaddr, (fexp == 2'b01) ? 7'h08 : 7'h10);
            tick();
            a_irr = 1'b0;
            if (i == 3) begin
                a_cv = 2'b00; a_rd = 2'b00;
            end
            settle();
            `CHK("fair_gap_cv", a_ocv, 0);
            `CHK("fair_gap_grant", a_grant, 0);
        end

        // ---- Single read by host 1 ----
        tick();
        a_cv = 2'b10; a_rd = 2'b10; a_wr = 2'b00; a_addr[1] = 7'h04;
        settle();
        `CHK("rd_before", a_ocv, 0);
        tick();
        settle();
        `CHK("rd_cv_rise", a_ocv, 1);
        `CHK("rd_grant", a_grant, 2'b10);
        `CHK("rd_read", a_or, 1);
        `CHK("rd_write", a_ow, 0);
        `CHK("rd_addr", a_oaddr, 7'h04);
        tick();
        settle();
        `CHK("rd_wait_rr", a_rr, 0);
        `CHK("rd_wait_cv", a_ocv, 1);
        tick();
        a_irr = 1'b1; a_ird = 32'h1234_5678; a_ist = 2'b00;
        settle();
        `CHK("rd_strobe", a_rr, 2'b10);
        `CHK("rd_data", a_rdata, 32'h1234_5678);
        `CHK("rd_status", a_st, 0);
        `CHK("rd_host0_quiet", a_rr[0], 0);
        tick();
        a_irr = 1'b0; a_cv = 2'b00; a_rd = 2'b00;
        settle();
        `CHK("rd_idle", a_ocv, 0);

        // ---- Masked write by host 0 (host 1 carries junk, not requesting) ----
        tick();
        a_cv = 2'b01; a_wr = 2'b01; a_rd = 2'b00; a_addr[0] = 7'h00;
        a_wd[0] = 32'hA5A5_0000; a_wm[0] = 32'hFFFF_0000;
        a_addr[1] = 7'h7F; a_wd[1] = 32'hDEAD_BEEF; a_wm[1] = 32'h0000_FFFF;
        settle();
        tick();
        settle();
        `CHK("wr_cv", a_ocv, 1);
        `CHK("wr_grant", a_grant, 2'b01);
        `CHK("wr_write", a_ow, 1);
        `CHK("wr_read", a_or, 0);
        `CHK("wr_addr", a_oaddr, 7'h00);
        `CHK("wr_data", a_owd, 32'hA5A5_0000);
        `CHK("wr_mask", a_owm, 32'hFFFF_0000);
        tick();
        a_irr = 1'b1;
        settle();
        `CHK("wr_strobe", a_rr, 2'b01);
        tick();
        a_irr = 1'b0; a_cv = 2'b00; a_wr = 2'b00;
        settle();
        `CHK("wr_idle", a_ocv, 0);

        // ---- Error routing: host 0, DECERR ----
        tick();
        a_cv = 2'b01; a_rd = 2'b01; a_addr[0] = 7'h0C;
        settle();
        tick();
        settle();
        `CHK("err_grant", a_grant, 2'b01);
        `CHK("err_addr", a_oaddr, 7'h0C);
        tick();
        a_irr = 1'b1; a_ist = 2'b11;
        settle();
        `CHK("err_strobe", a_rr, 2'b01);
        `CHK("err_status", a_st, 2'b11);
        tick();
        a_irr = 1'b0; a_ist = 2'b00; a_cv = 2'b00; a_rd = 2'b00;
        settle();
        `CHK("err_idle_cv", a_ocv, 0);
        `CHK("err_idle_grant", a_grant, 0);

        // ---- 3 hosts: pointer wrap and spurious response ----
        tick();
        b_cv = 3'b100; b_rd = 3'b100; b_addr[2] = 7'h20;
        settle();
        tick();
        settle();
        `CHK("wrap_grant2", b_grant, 3'b100);
        `CHK("wrap_addr2", b_oaddr, 7'h20);
        tick();
        b_irr = 1'b1;
        settle();
        `CHK("wrap_strobe2", b_rr, 3'b100);
        tick();
        b_irr = 1'b0; b_cv = 3'b000; b_rd = 3'b000;
        settle();
        `CHK("wrap_idle", b_ocv, 0);
        tick();
        b_irr = 1'b1;
        settle();
        `CHK("spur_rr", b_rr, 0);
        `CHK("spur_cv", b_ocv, 0);
        tick();
        b_irr = 1'b0; b_cv = 3'b001; b_wr = 3'b001; b_addr[0] = 7'h01;
        settle();
        `CHK("spur_nochange", b_ocv, 0);
        `CHK("spur_nograntr", b_grant, 0);
        tick();
        settle();
        `CHK("wrap_grant0", b_grant, 3'b001);
        tick();
        b_irr = 1'b1;
        settle();
        `CHK("wrap_strobe0", b_rr, 3'b001);
        tick();
        b_irr = 1'b0; b_cv = 3'b000; b_wr = 3'b000;
        settle();

        // ---- Reset mid-BUSY while host 1 owns the 2-host bus (pointer is 1) ----
        tick();
        a_cv = 2'b10; a_rd = 2'b10; a_addr[1] = 7'h08;
        settle();
        tick();
        a_cv = 2'b11; a_rd = 2'b11;
        settle();
        `CHK("rst_pre_grant", a_grant, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk_a_zero("rst_mid");
        a_irr = 1'b1;
        #1;
        `CHK("rst_no_strobe", a_rr, 0);
        tick();
        a_irr = 1'b0;
        rst_n = 1'b1;
        settle();
        `CHK("rst_after_idle", a_ocv, 0);
        tick();
        settle();
        `CHK("rst_first_grant", a_grant, 2'b01);
        tick();
        a_irr = 1'b1;
        settle();
        `CHK("rst_strobe_h0", a_rr, 2'b01);
        tick();
        a_irr = 1'b0; a_cv = 2'b10; a_rd = 2'b10;
        settle();
        tick();
        settle();
        `CHK("rst_second_grant", a_grant, 2'b10);
        tick();
        a_irr = 1'b1;
        settle();
        `CHK("rst_strobe_h1", a_rr, 2'b10);
        tick();
        a_irr = 1'b0; a_cv = 2'b00; a_rd = 2'b00;
        settle();

        // ---- Randomized traffic on the 3-host instance vs. the model ----
        m_busy = 1'b0; m_g = 0; m_p = 0;
        for (int h = 0; h < 3; h++) begin
            pend[h] = 1'b0; m_wr[h] = 1'b0; m_rd[h] = 1'b0;
            m_addr[h] = '0; m_wd[h] = '0; m_wm[h] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            for (int h = 0; h < 3; h++) begin
                if (!pend[h] && $urandom_range(0, 2) == 0) begin
                    pend[h]   = 1'b1;
                    kind      = $urandom_range(0, 2);
                    m_wr[h]   = (kind == 1);
                    m_rd[h]   = (kind == 2);
                    m_addr[h] = 7'($urandom);
                    m_wd[h]   = $urandom;
                    m_wm[h]   = $urandom;
                end
                b_cv[h]   = pend[h];
                b_wr[h]   = m_wr[h];
                b_rd[h]   = m_rd[h];
                b_addr[h] = m_addr[h];
                b_wd[h]   = m_wd[h];
                b_wm[h]   = m_wm[h];
            end
            b_irr = m_busy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            b_ird = $urandom;
            b_ist = 2'($urandom);
            settle();

            exp_grant = m_busy ? 3'(1 << m_g) : 3'b000;
            exp_rr    = b_irr ? exp_grant : 3'b000;
            `CHK("rnd_cv", b_ocv, m_busy);
            `CHK("rnd_grant", b_grant, exp_grant);
            `CHK("rnd_rr", b_rr, exp_rr);
            `CHK("rnd_wr", b_ow, m_busy ? m_wr[m_g] : 1'b0);
            `CHK("rnd_rd", b_or, m_busy ? m_rd[m_g] : 1'b0);
            `CHK("rnd_addr", b_oaddr, m_busy ? m_addr[m_g] : 7'h00);
            `CHK("rnd_wdata", b_owd, m_busy ? m_wd[m_g] : 32'h0);
            `CHK("rnd_wmask", b_owm, m_busy ? m_wm[m_g] : 32'h0);
            if (m_busy && b_irr) begin
                `CHK("rnd_rdata", b_rdata, b_ird);
                `CHK("rnd_status", b_st, b_ist);
            end
            checks++;
            if (b_grant !== exp_grant) begin
                errors++;
                $error("FAIL rnd_grant_direct observed=%0h expected=%0h", b_grant, exp_grant);
            end
            checks++;
            if (b_rr !== exp_rr) begin
                errors++;
                $error("FAIL rnd_rr_direct observed=%0h expected=%0h", b_rr, exp_rr);
            end

            if (!m_busy) begin
                if (pick(m_p) >= 0) begin
                    m_busy = 1'b1;
                    m_g    = pick(m_p);
                end
            end else if (b_irr) begin
                m_busy     = 1'b0;
                pend[m_g]  = 1'b0;
                m_p        = (m_g + 1) % 3;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`undef CHK
